// File: rtl/linescanner_pkg.sv
// Shared definitions for the line-scan capture controller.
// Holds the sequencer state encoding, the counter width and the timing defaults.
// No logic; imported by every file of the block.
package linescanner_pkg;

    // Width of the line counter, the pixel counter and the sequencer phase timer
    localparam int CNT_W = 16;

    // Default geometry and sensor timing, in pixel_clock cycles
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_CHANNELS        = 1;
    localparam int DEF_CDS_DLY         = 50;
    localparam int DEF_ADC_SKIP        = 8;
    localparam int DEF_ADC_TIMEOUT     = 1024;
    localparam int DEF_SAMPLE_LEN      = 50;
    localparam int DEF_POST_SAMPLE     = 7;
    localparam int DEF_INTEG_GAP       = 49;
    localparam int DEF_LOAD_DLY        = 5;
    localparam int DEF_PIXELS_PER_LINE = 2048;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RELEASE,
        ST_CDS_WAIT,
        ST_ADC_SKIP,
        ST_ADC_WAIT,
        ST_SAMPLE,
        ST_POST,
        ST_GAP
    } state_t;

endpackage

// File: rtl/linescanner_load_pulse_gen.sv
// Purpose: one load_pulse per end_adc high period, after LOAD_DLY+1 consecutive highs.
// Latency: load_pulse rises on the edge that samples the (LOAD_DLY+1)th consecutive high.
// Backpressure: none; free-running on end_adc, independent of the sequencer.
// Ports: pixel_clock, n_reset (sync, active-low), end_adc in, load_pulse out.
module linescanner_load_pulse_gen
    import linescanner_pkg::*;
#(
    parameter int LOAD_DLY = DEF_LOAD_DLY
) (
    input  logic pixel_clock,
    input  logic n_reset,
    input  logic end_adc,
    output logic load_pulse
);

    localparam int RUN_W = $clog2(LOAD_DLY + 2);
    localparam logic [RUN_W-1:0] FIRE_AT = RUN_W'(LOAD_DLY);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOAD_DLY + 1);

    // Number of consecutive end_adc highs already sampled; parks at RUN_MAX so
    // a long high period cannot wrap around and fire a second time.
    logic [RUN_W-1:0] run;

    always_ff @(posedge pixel_clock) begin
        if (!n_reset) begin
            run        <= '0;
            load_pulse <= 1'b0;
        end else if (!end_adc) begin
            run        <= '0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= (run == FIRE_AT);
            if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/linescanner_capture_ctrl.sv
// Purpose: line-scan sensor sequencer (rst_cvc/rst_cds/sample/load) plus pixel capture front end.
// Latency: pixels 1 cycle; line_done 1 cycle after the last pixel_valid; sensor timing set by parameters.
// Backpressure: none; the sensor cannot be stalled, every pixel is forwarded unconditionally.
// Ports: pixel_clock, n_reset (sync, active-low); enable/continuous/start trigger the sequence;
//        end_adc, lval, data from the sensor; rst_cvc, rst_cds, sample, load_pulse to the sensor;
//        busy, adc_timeout status; pixel_data/valid/sol and line_done/err/count downstream.
module linescanner_capture_ctrl
    import linescanner_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int CDS_DLY         = DEF_CDS_DLY,
    parameter int ADC_SKIP        = DEF_ADC_SKIP,
    parameter int ADC_TIMEOUT     = DEF_ADC_TIMEOUT,
    parameter int SAMPLE_LEN      = DEF_SAMPLE_LEN,
    parameter int POST_SAMPLE     = DEF_POST_SAMPLE,
    parameter int INTEG_GAP       = DEF_INTEG_GAP,
    parameter int LOAD_DLY        = DEF_LOAD_DLY,
    parameter int PIXELS_PER_LINE = DEF_PIXELS_PER_LINE
) (
    input  logic                           pixel_clock,
    input  logic                           n_reset,
    input  logic                           enable,
    input  logic                           continuous,
    input  logic                           start,
    input  logic                           end_adc,
    input  logic                           lval,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data,
    output logic                           rst_cvc,
    output logic                           rst_cds,
    output logic                           sample,
    output logic                           load_pulse,
    output logic                           busy,
    output logic                           adc_timeout,
    output logic [CHANNELS*DATA_WIDTH-1:0] pixel_data,
    output logic                           pixel_valid,
    output logic                           pixel_sol,
    output logic                           line_done,
    output logic                           line_err,
    output logic [CNT_W-1:0]               line_count
);

    // Phase timer terminal values: a phase lasting N cycles ends when the
    // timer, cleared on entry, reads N-1.
    localparam logic [CNT_W-1:0] CDS_LAST    = CNT_W'(CDS_DLY - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST   = CNT_W'(ADC_SKIP - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(ADC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_LEN - 1);
    localparam logic [CNT_W-1:0] POST_LAST   = CNT_W'(POST_SAMPLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(INTEG_GAP - 1);
    localparam logic [CNT_W-1:0] LINE_LEN    = CNT_W'(PIXELS_PER_LINE);

    // ------------------------------------------------------------------
    // Sensor sequencer
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             rst_cvc_nxt, rst_cds_nxt, sample_nxt, adc_timeout_nxt;

    always_ff @(posedge pixel_clock) begin
        if (!n_reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            rst_cvc     <= 1'b1;
            rst_cds     <= 1'b1;
            sample      <= 1'b0;
            adc_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            rst_cvc     <= rst_cvc_nxt;
            rst_cds     <= rst_cds_nxt;
            sample      <= sample_nxt;
            adc_timeout <= adc_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer + CNT_W'(1);
        rst_cvc_nxt     = rst_cvc;
        rst_cds_nxt     = rst_cds;
        sample_nxt      = sample;
        adc_timeout_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                // start is only looked at here, so a start seen mid-line is dropped
                if ((continuous && enable) || (!continuous && start)) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rst_cvc_nxt = 1'b0;
                timer_nxt   = '0;
                state_nxt   = ST_CDS_WAIT;
            end
            ST_CDS_WAIT: begin
                if (timer == CDS_LAST) begin
                    rst_cds_nxt = 1'b0;
                    timer_nxt   = '0;
                    state_nxt   = ST_ADC_SKIP;
                end
            end
            ST_ADC_SKIP: begin
                // end_adc straight after rst_cds release is not trusted
                if (timer == SKIP_LAST) begin
                    timer_nxt = '0;
                    state_nxt = ST_ADC_WAIT;
                end
            end
            ST_ADC_WAIT: begin
                if (end_adc) begin
                    sample_nxt = 1'b1;
                    timer_nxt  = '0;
                    state_nxt  = ST_SAMPLE;
                end else if (timer == TMO_LAST) begin
                    adc_timeout_nxt = 1'b1;
                    rst_cvc_nxt     = 1'b1;
                    rst_cds_nxt     = 1'b1;
                    timer_nxt       = '0;
                    state_nxt       = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (timer == SAMPLE_LAST) begin
                    sample_nxt = 1'b0;
                    timer_nxt  = '0;
                    state_nxt  = ST_POST;
                end
            end
            ST_POST: begin
                // enable is only consulted once the line is finished, so
                // dropping it mid-line never truncates the sensor sequence
                if (timer == POST_LAST) begin
                    rst_cvc_nxt = 1'b1;
                    rst_cds_nxt = 1'b1;
                    timer_nxt   = '0;
                    state_nxt   = (continuous && enable) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    timer_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (timer == GAP_LAST) begin
                    timer_nxt = '0;
                    state_nxt = ST_RELEASE;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    linescanner_load_pulse_gen #(
        .LOAD_DLY (LOAD_DLY)
    ) u_load_pulse_gen (
        .pixel_clock (pixel_clock),
        .n_reset     (n_reset),
        .end_adc     (end_adc),
        .load_pulse  (load_pulse)
    );

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    logic             valid_d;
    logic [CNT_W-1:0] pix_cnt;
    logic             line_end;

    // pixel_valid is still high but the sensor has already dropped lval
    assign line_end  = pixel_valid && !lval;
    assign pixel_sol = pixel_valid && !valid_d;

    always_ff @(posedge pixel_clock) begin
        if (!n_reset) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            valid_d     <= 1'b0;
            pix_cnt     <= '0;
            line_done   <= 1'b0;
            line_err    <= 1'b0;
            line_count  <= '0;
        end else begin
            pixel_data  <= data;
            pixel_valid <= lval;
            valid_d     <= pixel_valid;
            line_done   <= line_end;
            line_err    <= line_end && (pix_cnt != LINE_LEN);
            if (line_end) begin
                pix_cnt    <= '0;
                line_count <= line_count + CNT_W'(1);
            end else if (lval && (pix_cnt != '1)) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_linescanner_capture_ctrl.sv
module tb_linescanner_capture_ctrl;

    localparam int DW  = 8;
    localparam int CH  = 2;
    localparam int PW  = CH * DW;
    localparam int C   = 50;
    localparam int S   = 8;
    localparam int T   = 16;
    localparam int L   = 50;
    localparam int P   = 7;
    localparam int G   = 49;
    localparam int LD  = 5;
    localparam int PPL = 2048;

    logic          pixel_clock = 1'b0;
    logic          n_reset     = 1'b0;
    logic          enable      = 1'b0;
    logic          continuous  = 1'b0;
    logic          start       = 1'b0;
    logic          end_adc     = 1'b0;
    logic          lval        = 1'b0;
    logic [PW-1:0] data        = '0;

    logic          rst_cvc, rst_cds, sample, load_pulse, busy, adc_timeout;
    logic [PW-1:0] pixel_data;
    logic          pixel_valid, pixel_sol, line_done, line_err;
    logic [15:0]   line_count;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;   // consecutive end_adc highs sampled by the DUT
    int lines    = 0;   // completed lines since last reset

    linescanner_capture_ctrl #(
        .DATA_WIDTH      (DW),
        .CHANNELS        (CH),
        .CDS_DLY         (C),
        .ADC_SKIP        (S),
        .ADC_TIMEOUT     (T),
        .SAMPLE_LEN      (L),
        .POST_SAMPLE     (P),
        .INTEG_GAP       (G),
        .LOAD_DLY        (LD),
        .PIXELS_PER_LINE (PPL)
    ) dut (
        .pixel_clock (pixel_clock),
        .n_reset     (n_reset),
        .enable      (enable),
        .continuous  (continuous),
        .start       (start),
        .end_adc     (end_adc),
        .lval        (lval),
        .data        (data),
        .rst_cvc     (rst_cvc),
        .rst_cds     (rst_cds),
        .sample      (sample),
        .load_pulse  (load_pulse),
        .busy        (busy),
        .adc_timeout (adc_timeout),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_sol   (pixel_sol),
        .line_done   (line_done),
        .line_err    (line_err),
        .line_count  (line_count)
    );

    always #5 pixel_clock = ~pixel_clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; load_pulse is checked against the run-length rule every cycle.
    task automatic tick();
        @(posedge pixel_clock);
        if (!n_reset)     run_len = 0;
        else if (end_adc) run_len++;
        else              run_len = 0;
        #1;
        chk("load_pulse", 32'(load_pulse), 32'(run_len == LD + 1));
    endtask

    task automatic chk_reset(input string ctx);
        chk({ctx, ".rst_cvc"},     32'(rst_cvc),     32'(1));
        chk({ctx, ".rst_cds"},     32'(rst_cds),     32'(0) + 32'(1));
        chk({ctx, ".sample"},      32'(sample),      32'(0));
        chk({ctx, ".busy"},        32'(busy),        32'(0));
        chk({ctx, ".adc_timeout"}, 32'(adc_timeout), 32'(0));
        chk({ctx, ".pixel_valid"}, 32'(pixel_valid), 32'(0));
        chk({ctx, ".pixel_sol"},   32'(pixel_sol),   32'(0));
        chk({ctx, ".line_done"},   32'(line_done),   32'(0));
        chk({ctx, ".line_err"},    32'(line_err),    32'(0));
        chk({ctx, ".pixel_data"},  32'(pixel_data),  32'(0));
        chk({ctx, ".line_count"},  32'(line_count),  32'(0));
    endtask

    // One sensor line sequence. The edge following the call is the edge on
    // which the DUT leaves IDLE/GAP (k=0). end_adc is first sampled high at
    // edge a = 2+C+S+adc_rel for hold cycles (hold=0: never -> timeout).
    task automatic run_seq(input int adc_rel, input int hold, input bit cont,
                           input int drop_k, input int spur_k, input int abort_k,
                           input bit early, input int tail);
        bit tmo;
        int a, eend, idle_at, kend;
        tmo  = (hold == 0);
        a    = 2 + C + S + adc_rel;
        eend = tmo ? (1 + C + S + T) : (a + L + P);
        if (tmo || !cont)       idle_at = eend;
        else if (drop_k < 0)    idle_at = 1 << 30;
        else if (drop_k < eend) idle_at = eend;
        else                    idle_at = drop_k + 1;
        kend = (cont && !tmo && drop_k < 0) ? (eend + G - 1) : (idle_at + tail);
        for (int k = 0; k <= kend; k++) begin
            tick();
            chk("rst_cvc",     32'(rst_cvc),     32'(!(k >= 1 && k < eend)));
            chk("rst_cds",     32'(rst_cds),     32'(!(k >= 1 + C && k < eend)));
            chk("sample",      32'(sample),      32'(!tmo && k >= a && k < a + L));
            chk("busy",        32'(busy),        32'(k < idle_at));
            chk("adc_timeout", 32'(adc_timeout), 32'(tmo && k == eend));
            start   = (k + 1 == spur_k);
            if (drop_k >= 0 && k == drop_k) enable = 1'b0;
            end_adc = (early && k + 1 >= 2 + C && k + 1 <= 4 + C) ||
                      (!tmo && k + 1 >= a && k + 1 < a + hold);
            if (k == abort_k) begin
                n_reset = 1'b0;
                tick();
                chk_reset("abort");
                n_reset = 1'b1;
                end_adc = 1'b0;
                lines   = 0;
                return;
            end
        end
    endtask

    // end_adc high for hi cycles then low for lo cycles; one pulse iff hi >= LD+1.
    task automatic adc_pulse(input int hi, input int lo);
        int seen;
        seen = 0;
        end_adc = 1'b1;
        for (int i = 0; i < hi; i++) begin
            tick();
            if (load_pulse) seen++;
        end
        end_adc = 1'b0;
        for (int i = 0; i < lo; i++) begin
            tick();
            if (load_pulse) seen++;
        end
        chk("load_pulse_count", 32'(seen), 32'(hi >= LD + 1));
    endtask

    // One line of len pixels followed by gap idle cycles after line_done.
    task automatic pix_line(input int len, input bit ramp, input int gap);
        logic [PW-1:0] d;
        for (int i = 1; i <= len; i++) begin
            d    = ramp ? PW'(i) : PW'($urandom);
            lval = 1'b1;
            data = d;
            tick();
            chk("pixel_valid", 32'(pixel_valid), 32'(1));
            chk("pixel_data",  32'(pixel_data),  32'(d));
            chk("pixel_sol",   32'(pixel_sol),   32'(i == 1));
            chk("line_done",   32'(line_done),   32'(0));
        end
        d    = PW'($urandom);
        lval = 1'b0;
        data = d;
        tick();
        lines++;
        chk("end.pixel_valid", 32'(pixel_valid), 32'(0));
        chk("end.pixel_data",  32'(pixel_data),  32'(d));
        chk("end.line_done",   32'(line_done),   32'(1));
        chk("end.line_err",    32'(line_err),    32'(len != PPL));
        chk("end.line_count",  32'(line_count),  32'(lines % 65536));
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("gap.line_done",   32'(line_done),   32'(0));
            chk("gap.pixel_valid", 32'(pixel_valid), 32'(0));
        end
    endtask

    initial begin
        int ar;
        // reset state
        n_reset = 1'b0;
        repeat (3) tick();
        chk_reset("reset");
        n_reset = 1'b1;
        tick();

        // continuous mode: two chained lines, then enable drops mid-line
        continuous = 1'b1;
        enable     = 1'b1;
        run_seq(1, 20, 1'b1, -1, -1, -1, 1'b0, 0);
        run_seq(0, 8, 1'b1, -1, -1, -1, 1'b0, 0);
        run_seq(int'($urandom_range(0, 12)), 25, 1'b1, 20, -1, -1, 1'b1, 5);

        // enable dropped during the inter-line gap
        enable = 1'b1;
        ar     = int'($urandom_range(0, 12));
        run_seq(ar, 3, 1'b1, 2 + C + S + ar + L + P + 10, -1, -1, 1'b0, 5);

        // single-shot with a start pulse during SAMPLE that must be ignored
        enable     = 1'b0;
        continuous = 1'b0;
        start      = 1'b1;
        run_seq(3, 12, 1'b0, -1, 2 + C + S + 3 + 10, -1, 1'b0, 10);

        // ADC timeout (a short end_adc blip during the skip window is ignored)
        start = 1'b1;
        run_seq(0, 0, 1'b0, -1, -1, -1, 1'b1, 5);

        // randomized single-shot lines
        for (int r = 0; r < 3; r++) begin
            start = 1'b1;
            run_seq(int'($urandom_range(0, 12)), int'($urandom_range(1, 30)),
                    1'b0, -1, -1, -1, 1'($urandom_range(0, 1)), 3);
        end

        // load pulse generator around the LOAD_DLY boundary
        adc_pulse(20, 4);
        adc_pulse(7, 3);
        adc_pulse(LD + 1, 2);
        adc_pulse(LD, 2);
        adc_pulse(1, 1);
        for (int r = 0; r < 4; r++) begin
            adc_pulse(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
        end

        // pixel path: exact, short, long, random and back-to-back lines
        pix_line(PPL, 1'b1, 3);
        pix_line(PPL - 1, 1'b0, 2);
        pix_line(PPL + 2, 1'b0, 0);
        pix_line(int'($urandom_range(PPL - 8, PPL + 8)), 1'b0, 2);
        pix_line(1, 1'b0, 2);

        // reset in the middle of SAMPLE
        start = 1'b1;
        run_seq(2, 10, 1'b0, -1, -1, 2 + C + S + 2 + 5, 1'b0, 0);
        tick();
        chk("post_abort.busy", 32'(busy), 32'(0));
        pix_line(PPL, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
